// File: rtl/ov7725_cfg_seq_pkg.sv
// Shared definitions for the OV7725 bring-up sequencer: sensor IDs, the
// sequencer state enum and the SCCB configuration table.
package ov7725_cfg_pkg;

  localparam logic [7:0] CFG_SIZE       = 8'd36;
  localparam logic [7:0] OV7725_PID     = 8'h77;
  localparam logic [7:0] OV7725_VER     = 8'h21;
  localparam logic [7:0] OV7725_SCCB_ID = 8'h42;

  typedef enum logic [2:0] {
    S_PWDN, S_RST, S_BOOT, S_ID, S_CFG, S_FAIL, S_DONE, S_ERR
  } cfg_state_t;

  // Entries 0/1 read back PID/VER, entry 2 soft-resets, the rest set up RGB565.
  function automatic logic [23:0] cfg_lut(input logic [7:0] index);
    logic [15:0] rd;
    case (index)
      8'd0:    rd = 16'h0A00;
      8'd1:    rd = 16'h0B00;
      8'd2:    rd = 16'h1280;
      8'd3:    rd = 16'h3D03;
      8'd4:    rd = 16'h1500;
      8'd5:    rd = 16'h1722;
      8'd6:    rd = 16'h18A4;
      8'd7:    rd = 16'h1907;
      8'd8:    rd = 16'h1AF0;
      8'd9:    rd = 16'h3200;
      8'd10:   rd = 16'h29A0;
      8'd11:   rd = 16'h2CF0;
      8'd12:   rd = 16'h2A00;
      8'd13:   rd = 16'h1101;
      8'd14:   rd = 16'h0D41;
      8'd15:   rd = 16'h1421;
      8'd16:   rd = 16'h22FF;
      8'd17:   rd = 16'h2301;
      8'd18:   rd = 16'h2434;
      8'd19:   rd = 16'h253C;
      8'd20:   rd = 16'h26A1;
      8'd21:   rd = 16'h6BAA;
      8'd22:   rd = 16'h13FF;
      8'd23:   rd = 16'h900A;
      8'd24:   rd = 16'h9101;
      8'd25:   rd = 16'h9201;
      8'd26:   rd = 16'h9301;
      8'd27:   rd = 16'h945F;
      8'd28:   rd = 16'h9553;
      8'd29:   rd = 16'h9611;
      8'd30:   rd = 16'h971A;
      8'd31:   rd = 16'h983D;
      8'd32:   rd = 16'h995A;
      8'd33:   rd = 16'h9A1E;
      8'd34:   rd = 16'h0E65;
      8'd35:   rd = 16'h1206;
      default: rd = 16'h0000;
    endcase
    return {OV7725_SCCB_ID, rd};
  endfunction

endpackage

// File: rtl/ov7725_cfg_seq_rom.sv
// Registered configuration table lookup, one cycle of latency.
module ov7725_cfg_rom
  import ov7725_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  index,
  output logic [23:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= '0;
    else        data <= cfg_lut(index);
  end

endmodule

// File: rtl/ov7725_cfg_seq.sv
// OV7725 bring-up sequencer: power/reset pin sequencing, I2C controller release
// and product-ID check with retries. ID check and timeout need CMOS_ID_CHECK_EN.
module ov7725_cfg_seq
  import ov7725_cfg_pkg::*;
#(
  parameter int PWDN_CYC  = 100_000,
  parameter int RST_CYC   = 100_000,
  parameter int BOOT_CYC  = 200_000,
  parameter int ID_TO_CYC = 50_000_000,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        cmos_pwdn,
  output logic        cmos_rst_n,
  output logic        i2c_rst_n,
  output logic [7:0]  i2c_config_size,
  input  logic [7:0]  i2c_config_index,
  output logic [23:0] i2c_config_data,
  input  logic        i2c_config_done,
  input  logic [7:0]  i2c_rdata,
  output logic        cfg_done,
  output logic        id_err,
  output logic [15:0] cmos_pid
);

`ifdef CMOS_ID_CHECK_EN
  localparam bit ID_CHECK = 1'b1;
`else
  localparam bit ID_CHECK = 1'b0;
`endif

  localparam logic [31:0] PWDN_LAST = 32'(PWDN_CYC - 1);
  localparam logic [31:0] RST_LAST  = 32'(RST_CYC - 1);
  localparam logic [31:0] BOOT_LAST = 32'(BOOT_CYC - 1);
  localparam logic [31:0] TO_LAST   = 32'(ID_TO_CYC - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  cfg_state_t  state;
  logic [31:0] cnt;
  logic [7:0]  retry;
  logic [7:0]  idx_q;
  logic [7:0]  pid_q;
  logic [7:0]  ver_q;
  logic        id_chk;
  logic        id_err_q;

  assign i2c_config_size = CFG_SIZE;
  assign cmos_pid        = {pid_q, ver_q};
  assign id_err          = ID_CHECK & id_err_q;

  ov7725_cfg_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .index (i2c_config_index),
    .data  (i2c_config_data)
  );

  // Held at zero while the controller is in reset so every attempt restarts at 0->1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= i2c_rst_n ? i2c_config_index : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PWDN;
      cnt        <= '0;
      retry      <= '0;
      pid_q      <= '0;
      ver_q      <= '0;
      id_chk     <= 1'b0;
      id_err_q   <= 1'b0;
      cfg_done   <= 1'b0;
      cmos_pwdn  <= 1'b1;
      cmos_rst_n <= 1'b0;
      i2c_rst_n  <= 1'b0;
    end else begin
      cnt <= cnt + 32'd1;
      case (state)
        S_PWDN: begin
          cmos_pwdn  <= 1'b1;
          cmos_rst_n <= 1'b0;
          i2c_rst_n  <= 1'b0;
          if (cnt == PWDN_LAST) begin
            state <= S_RST;
            cnt   <= '0;
          end
        end
        S_RST: begin
          cmos_pwdn  <= 1'b0;
          cmos_rst_n <= 1'b0;
          i2c_rst_n  <= 1'b0;
          if (cnt == RST_LAST) begin
            state <= S_BOOT;
            cnt   <= '0;
          end
        end
        S_BOOT: begin
          cmos_rst_n <= 1'b1;
          if (cnt == BOOT_LAST) begin
            state <= S_ID;
            cnt   <= '0;
          end
        end
        // Timeout has priority over a pending compare or a fresh index change.
        S_ID: begin
          i2c_rst_n <= 1'b1;
          if (ID_CHECK && cnt == TO_LAST) begin
            state  <= S_FAIL;
            cnt    <= '0;
            id_chk <= 1'b0;
          end else if (id_chk) begin
            id_chk <= 1'b0;
            cnt    <= '0;
            state  <= (pid_q == OV7725_PID && ver_q == OV7725_VER) ? S_CFG : S_FAIL;
          end else if (idx_q == 8'd0 && i2c_config_index == 8'd1) begin
            pid_q <= i2c_rdata;
          end else if (idx_q == 8'd1 && i2c_config_index == 8'd2) begin
            ver_q <= i2c_rdata;
            if (ID_CHECK) begin
              id_chk <= 1'b1;
            end else begin
              state <= S_CFG;
              cnt   <= '0;
            end
          end
        end
        S_CFG: begin
          if (i2c_config_done) begin
            cfg_done <= 1'b1;
            state    <= S_DONE;
            cnt      <= '0;
          end
        end
        S_FAIL: begin
          i2c_rst_n <= 1'b0;
          retry     <= retry + 8'd1;
          cnt       <= '0;
          state     <= (retry + 8'd1 == RETRY_MAX) ? S_ERR : S_RST;
        end
        S_DONE: begin
        end
        S_ERR: begin
          id_err_q   <= 1'b1;
          i2c_rst_n  <= 1'b0;
          cmos_rst_n <= 1'b1;
        end
        default: state <= S_PWDN;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7725_cfg_seq.sv
// Scoreboard bench for ov7725_cfg_seq: stimulus queues cycle-stamped expectations,
// a negedge monitor compares them. Extra scenarios run when CMOS_ID_CHECK_EN is defined.
module tb_ov7725_cfg_seq;

  localparam int P  = 10;
  localparam int R  = 10;
  localparam int B  = 20;
  localparam int TO = 200;
  localparam int MR = 3;

  localparam int SEL_PWDN = 0, SEL_CRST = 1, SEL_I2C = 2, SEL_DATA = 3, SEL_DONE = 4,
                 SEL_ERR = 5, SEL_PID = 6, SEL_I2CR = 7, SEL_CRSTR = 8, SEL_SIZE = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i2c_config_index = '0;
  logic [7:0]  i2c_rdata = '0;
  logic        i2c_config_done = 1'b0;
  logic        cmos_pwdn, cmos_rst_n, i2c_rst_n, cfg_done, id_err;
  logic [7:0]  i2c_config_size;
  logic [23:0] i2c_config_data;
  logic [15:0] cmos_pid;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   i2cRises = 0;
  int   crstRises = 0;
  logic i2cPrev = 1'b0;
  logic crstPrev = 1'b0;

  ov7725_cfg_seq #(
    .PWDN_CYC (P), .RST_CYC (R), .BOOT_CYC (B), .ID_TO_CYC (TO), .MAX_RETRY (MR)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmos_pwdn        (cmos_pwdn),
    .cmos_rst_n       (cmos_rst_n),
    .i2c_rst_n        (i2c_rst_n),
    .i2c_config_size  (i2c_config_size),
    .i2c_config_index (i2c_config_index),
    .i2c_config_data  (i2c_config_data),
    .i2c_config_done  (i2c_config_done),
    .i2c_rdata        (i2c_rdata),
    .cfg_done         (cfg_done),
    .id_err           (id_err),
    .cmos_pid         (cmos_pid)
  );

  always #5 clk = ~clk;

  // Counts rising clock edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      SEL_PWDN:  return 32'(cmos_pwdn);
      SEL_CRST:  return 32'(cmos_rst_n);
      SEL_I2C:   return 32'(i2c_rst_n);
      SEL_DATA:  return 32'(i2c_config_data);
      SEL_DONE:  return 32'(cfg_done);
      SEL_ERR:   return 32'(id_err);
      SEL_PID:   return 32'(cmos_pid);
      SEL_I2CR:  return 32'(i2cRises);
      SEL_CRSTR: return 32'(crstRises);
      default:   return 32'(i2c_config_size);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic recordFail(input string name);
    total++;
    $display("[TB] FAIL %s: got no response, expected one in time", name);
  endtask

  // Monitor: tracks pulse counts and checks every expectation due this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        i2cRises  = 0;
        crstRises = 0;
      end else begin
        if (i2c_rst_n && !i2cPrev) i2cRises++;
        if (cmos_rst_n && !crstPrev) crstRises++;
      end
      i2cPrev  = i2c_rst_n;
      crstPrev = cmos_rst_n;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc < cyc) begin
          recordFail({q[i].name, " missed"});
          q.delete(i);
        end else if (q[i].cyc == cyc) begin
          checkOutput(q[i].name, sample(q[i].sel), q[i].val);
          q.delete(i);
        end
      end
    end
  end

  task automatic pushExp(input string name, input int sel, input int at, input logic [31:0] val);
    exp_t e;
    e.cyc  = at;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] idx, input logic [7:0] rd, input logic done);
    i2c_config_index = idx;
    i2c_rdata        = rd;
    i2c_config_done  = done;
  endtask

  task automatic pushResetState();
    pushExp("rst cmos_pwdn", SEL_PWDN, 0, 32'd1);
    pushExp("rst cmos_rst_n", SEL_CRST, 0, 32'd0);
    pushExp("rst i2c_rst_n", SEL_I2C, 0, 32'd0);
    pushExp("rst config_data", SEL_DATA, 0, 32'd0);
    pushExp("rst cfg_done", SEL_DONE, 0, 32'd0);
    pushExp("rst id_err", SEL_ERR, 0, 32'd0);
    pushExp("rst cmos_pid", SEL_PID, 0, 32'd0);
    pushExp("config_size", SEL_SIZE, 0, 32'd36);
  endtask

  task automatic pushTimeline();
    pushExp("pwdn held", SEL_PWDN, P, 32'd1);
    pushExp("pwdn release", SEL_PWDN, P + 1, 32'd0);
    pushExp("cmos_rst held", SEL_CRST, P + R, 32'd0);
    pushExp("cmos_rst release", SEL_CRST, P + R + 1, 32'd1);
    pushExp("i2c_rst held", SEL_I2C, P + R + B, 32'd0);
    pushExp("i2c_rst release", SEL_I2C, P + R + B + 1, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 2000 && q.size() != 0; n++) nextCycle();
    if (q.size() != 0) begin
      recordFail("scoreboard drain");
      q.delete();
    end
  endtask

  task automatic resetDut();
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    applyStimulus(8'd0, 8'd0, 1'b0);
    pushResetState();
    nextCycle();
    nextCycle();
    pushTimeline();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitI2cHigh(output int t0);
    bit found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      nextCycle();
      if (i2c_rst_n) found = 1'b1;
    end
    t0 = cyc;
    if (!found) recordFail("i2c_rst_n release wait");
  endtask

  // kind: 0 = ID passes, 1 = mismatch with retry, 2 = mismatch on final attempt.
  task automatic doAttempt(input logic [7:0] pid, input logic [7:0] ver, input int kind,
                           input logic pokeDone);
    int t0;
    waitI2cHigh(t0);
    applyStimulus(8'd1, pid, pokeDone);
    nextCycle();
    applyStimulus(8'd2, ver, 1'b0);
    pushExp("cmos_pid", SEL_PID, t0 + 2, 32'({pid, ver}));
    pushExp("data idx2", SEL_DATA, t0 + 2, 32'h0042_1280);
    if (pokeDone) pushExp("cfg_done ignored in S_ID", SEL_DONE, t0 + 2, 32'd0);
    if (kind != 0) begin
      pushExp("i2c_rst before fail", SEL_I2C, t0 + 3, 32'd1);
      pushExp("i2c_rst fail pulse", SEL_I2C, t0 + 4, 32'd0);
      if (kind == 1) begin
        pushExp("cmos_rst before repulse", SEL_CRST, t0 + 4, 32'd1);
        pushExp("cmos_rst repulse", SEL_CRST, t0 + 5, 32'd0);
        pushExp("i2c_rst retry held", SEL_I2C, t0 + 34, 32'd0);
        pushExp("i2c_rst retry release", SEL_I2C, t0 + 35, 32'd1);
      end else begin
        pushExp("id_err before", SEL_ERR, t0 + 4, 32'd0);
        pushExp("id_err set", SEL_ERR, t0 + 5, 32'd1);
        pushExp("err cmos_rst_n", SEL_CRST, t0 + 6, 32'd1);
        pushExp("err cfg_done", SEL_DONE, t0 + 6, 32'd0);
        pushExp("err i2c_rst_n", SEL_I2C, t0 + 6, 32'd0);
        pushExp("err i2c pulses", SEL_I2CR, t0 + 6, 32'd3);
      end
      nextCycle();
      nextCycle();
      nextCycle();
      applyStimulus(8'd0, 8'd0, 1'b0);
    end
  endtask

  task automatic finishCfg(input int rises);
    nextCycle();
    applyStimulus(8'd200, 8'd0, 1'b0);
    pushExp("data out of range", SEL_DATA, cyc + 1, 32'h0042_0000);
    pushExp("cfg_done before", SEL_DONE, cyc + 1, 32'd0);
    nextCycle();
    applyStimulus(8'd30, 8'd0, 1'b1);
    pushExp("data idx30", SEL_DATA, cyc + 1, 32'h0042_971A);
    pushExp("cfg_done set", SEL_DONE, cyc + 1, 32'd1);
    nextCycle();
    applyStimulus(8'd30, 8'd0, 1'b0);
    pushExp("done id_err", SEL_ERR, cyc + 1, 32'd0);
    pushExp("done i2c_rst_n", SEL_I2C, cyc + 1, 32'd1);
    pushExp("done i2c pulses", SEL_I2CR, cyc + 1, 32'(rises));
    pushExp("done cmos_rst pulses", SEL_CRSTR, cyc + 1, 32'(rises));
  endtask

  initial begin
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    pushResetState();
    nextCycle();
    nextCycle();
    pushTimeline();
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal bring-up, then reset while sitting in S_CFG at index 30.
    doAttempt(8'h77, 8'h21, 0, 1'b0);
    nextCycle();
    applyStimulus(8'd200, 8'd0, 1'b0);
    pushExp("data idx200", SEL_DATA, cyc + 1, 32'h0042_0000);
    nextCycle();
    applyStimulus(8'd30, 8'd0, 1'b0);
    pushExp("data idx30 pre-reset", SEL_DATA, cyc + 1, 32'h0042_971A);
    nextCycle();
    resetDut();

`ifdef CMOS_ID_CHECK_EN
    doAttempt(8'h77, 8'h21, 0, 1'b1);
`else
    doAttempt(8'h00, 8'h55, 0, 1'b1);
`endif
    finishCfg(1);

`ifdef CMOS_ID_CHECK_EN
    resetDut();
    doAttempt(8'h76, 8'h21, 1, 1'b0);
    doAttempt(8'h77, 8'h21, 0, 1'b0);
    finishCfg(2);

    resetDut();
    doAttempt(8'h77, 8'h20, 1, 1'b0);
    doAttempt(8'h77, 8'h20, 1, 1'b0);
    doAttempt(8'h77, 8'h20, 2, 1'b0);

    // No slave: the index never moves, so each attempt ends by timeout.
    resetDut();
    pushExp("to1 i2c high", SEL_I2C, 240, 32'd1);
    pushExp("to1 i2c low", SEL_I2C, 241, 32'd0);
    pushExp("to2 i2c release", SEL_I2C, 272, 32'd1);
    pushExp("to2 i2c low", SEL_I2C, 472, 32'd0);
    pushExp("to3 i2c release", SEL_I2C, 503, 32'd1);
    pushExp("to id_err before", SEL_ERR, 703, 32'd0);
    pushExp("to id_err set", SEL_ERR, 704, 32'd1);
    pushExp("to i2c held", SEL_I2C, 704, 32'd0);
    pushExp("to i2c pulses", SEL_I2CR, 704, 32'd3);
    pushExp("to cfg_done", SEL_DONE, 704, 32'd0);
`endif

    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
